// File: rtl/rpsc_interlock_latch.sv
// RF-permit interlock: per-channel fault debounce and sticky latch, first-fault capture,
// and a TRIP/HOLDOFF/PERMIT state machine gating the registered RF-permit line.
module rpsc_interlock_latch #(
    parameter int N_FAULT      = 5,
    parameter int DEBOUNCE_CYC = 4,
    parameter int HOLDOFF_CYC  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_FAULT-1:0] fault_in,
    input  logic [N_FAULT-1:0] fault_mask,
    input  logic               g2_ok_b,
    input  logic               dr_amp_ok_b,
    input  logic               ack,
    output logic [N_FAULT-1:0] fault_latched,
    output logic [N_FAULT-1:0] first_fault,
    output logic               alarm_b,
    output logic               rf_perm_b,
    output logic [7:0]         trip_cnt
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(HOLDOFF_CYC + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC);
    localparam logic [DW-1:0] DEB_PRE  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_CYC);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic [1:0] {
        ST_TRIP    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_PERMIT  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [HW-1:0]        hold_r, hold_s;
    logic [DW-1:0]        deb_r [N_FAULT];
    logic [DW-1:0]        deb_s [N_FAULT];
    logic [N_FAULT-1:0]   latched_r, latched_s;
    logic [N_FAULT-1:0]   first_r, first_s;
    logic [7:0]           cnt_r, cnt_s;
    logic                 alarm_r, alarm_s;
    logic                 rf_r, rf_s;
    logic [N_FAULT-1:0]   eff_s;
    logic [N_FAULT-1:0]   new_set_s;
    logic                 latch_evt_s;
    logic                 ack_ok_s;

    // Per-channel debounce counters and detection of bits latching on this edge
    always_comb begin
        eff_s     = fault_in & ~fault_mask;
        new_set_s = '0;
        for (int i = 0; i < N_FAULT; i++) begin
            if (eff_s[i]) begin
                deb_s[i]     = (deb_r[i] == DEB_MAX) ? deb_r[i] : deb_r[i] + DEB_ONE;
                new_set_s[i] = (deb_r[i] == DEB_PRE) & ~latched_r[i];
            end else begin
                deb_s[i]     = '0;
                new_set_s[i] = 1'b0;
            end
        end
        latch_evt_s = |new_set_s;
        // A latch on the same edge always beats an ack
        ack_ok_s    = (state_r == ST_TRIP) & ack & ~(|eff_s) & ~latch_evt_s;
    end

    // Next-state, holdoff, latch/first-fault/trip-count and output pre-computation
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        latched_s = latched_r | new_set_s;
        first_s   = first_r;
        cnt_s     = cnt_r;
        case (state_r)
            ST_TRIP: begin
                if (ack_ok_s) begin
                    state_s   = ST_HOLDOFF;
                    hold_s    = HOLD_MAX;
                    latched_s = '0;
                    first_s   = '0;
                end else begin
                    state_s   = ST_TRIP;
                end
            end
            ST_HOLDOFF: begin
                if (latch_evt_s) begin
                    state_s = ST_TRIP;
                    first_s = new_set_s;
                    cnt_s   = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
                end else if (hold_r <= HOLD_ONE) begin
                    state_s = ST_PERMIT;
                end else begin
                    hold_s  = hold_r - HOLD_ONE;
                end
            end
            ST_PERMIT: begin
                if (latch_evt_s) begin
                    state_s = ST_TRIP;
                    first_s = new_set_s;
                    cnt_s   = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
                end else begin
                    state_s = ST_PERMIT;
                end
            end
            default: begin
                state_s = ST_HOLDOFF;
                hold_s  = HOLD_MAX;
            end
        endcase
        alarm_s = ~(|latched_s);
        rf_s    = (state_s != ST_PERMIT) | g2_ok_b | dr_amp_ok_b;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_HOLDOFF;
            hold_r    <= HOLD_MAX;
            latched_r <= '0;
            first_r   <= '0;
            cnt_r     <= 8'd0;
            alarm_r   <= 1'b1;
            rf_r      <= 1'b1;
            for (int i = 0; i < N_FAULT; i++) begin
                deb_r[i] <= '0;
            end
        end else begin
            state_r   <= state_s;
            hold_r    <= hold_s;
            latched_r <= latched_s;
            first_r   <= first_s;
            cnt_r     <= cnt_s;
            alarm_r   <= alarm_s;
            rf_r      <= rf_s;
            for (int i = 0; i < N_FAULT; i++) begin
                deb_r[i] <= deb_s[i];
            end
        end
    end

    assign fault_latched = latched_r;
    assign first_fault   = first_r;
    assign alarm_b       = alarm_r;
    assign rf_perm_b     = rf_r;
    assign trip_cnt      = cnt_r;

endmodule

// File: tb/tb_rpsc_interlock_latch.sv
// Directed plus randomized bench for rpsc_interlock_latch, checked against a
// run-length / absolute-edge-time reference model.
module tb_rpsc_interlock_latch;

    localparam int N = 5;
    localparam int D = 4;
    localparam int H = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] fault_in, fault_mask;
    logic         g2_ok_b, dr_amp_ok_b, ack;
    logic [N-1:0] fault_latched, first_fault;
    logic         alarm_b, rf_perm_b;
    logic [7:0]   trip_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int           run [N];
    logic [N-1:0] m_lat, m_first;
    int           m_cnt;
    bit           m_tripped;
    int           permit_edge;
    int           edge_n = 0;

    rpsc_interlock_latch #(.N_FAULT(N), .DEBOUNCE_CYC(D), .HOLDOFF_CYC(H)) dut (
        .clk(clk), .reset(reset), .fault_in(fault_in), .fault_mask(fault_mask),
        .g2_ok_b(g2_ok_b), .dr_amp_ok_b(dr_amp_ok_b), .ack(ack),
        .fault_latched(fault_latched), .first_fault(first_fault),
        .alarm_b(alarm_b), .rf_perm_b(rf_perm_b), .trip_cnt(trip_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] f, input logic [N-1:0] m,
                        input logic g2, input logic dr, input logic ak);
        logic [N-1:0] e, newly;
        bit           permit;
        logic         exp_rf;
        reset = r; fault_in = f; fault_mask = m; g2_ok_b = g2; dr_amp_ok_b = dr; ack = ak;
        @(posedge clk);
        edge_n++;
        if (r) begin
            for (int i = 0; i < N; i++) run[i] = 0;
            m_lat = '0; m_first = '0; m_cnt = 0; m_tripped = 0;
            permit_edge = edge_n + H;
        end else begin
            e = f & ~m;
            newly = '0;
            for (int i = 0; i < N; i++) begin
                run[i] = e[i] ? ((run[i] < D) ? run[i] + 1 : D) : 0;
                if (run[i] == D && !m_lat[i]) newly[i] = 1'b1;
            end
            if (newly != '0) begin
                if (!m_tripped) begin
                    m_first = newly;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_tripped = 1;
                end
                m_lat |= newly;
            end else if (m_tripped && ak && e == '0) begin
                m_lat = '0; m_first = '0; m_tripped = 0;
                permit_edge = edge_n + H;
            end
        end
        permit = !r && !m_tripped && (edge_n >= permit_edge);
        exp_rf = r ? 1'b1 : (!permit || g2 || dr);
        #1;
        chk("latched", 32'(fault_latched), 32'(m_lat));
        chk("first", 32'(first_fault), 32'(m_first));
        chk("alarm_b", 32'(alarm_b), 32'(m_lat == '0));
        chk("rf_perm_b", 32'(rf_perm_b), 32'(exp_rf));
        chk("trip_cnt", 32'(trip_cnt), 32'(m_cnt));
    endtask

    task automatic idle(input int n, input logic [N-1:0] f);
        for (int k = 0; k < n; k++) step(1'b0, f, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [N-1:0] rf_v, rm_v;
        logic         rg_v, rd_v, ra_v;

        // Power-up
        step(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_rf", 32'(rf_perm_b), 32'd1);
        chk("rst_alarm", 32'(alarm_b), 32'd1);
        idle(15, '0);
        chk("pwr_e15_rf", 32'(rf_perm_b), 32'd1);
        idle(1, '0);
        chk("pwr_e16_rf", 32'(rf_perm_b), 32'd0);

        // Glitch of D-1 edges, then a full-length fault
        idle(3, 5'b00100);
        idle(1, '0);
        chk("glitch_lat", 32'(fault_latched), 32'd0);
        idle(4, 5'b00100);
        chk("latch_lat", 32'(fault_latched), 32'h04);
        chk("latch_first", 32'(first_fault), 32'h04);
        chk("latch_alarm", 32'(alarm_b), 32'd0);
        chk("latch_rf", 32'(rf_perm_b), 32'd1);
        chk("latch_cnt", 32'(trip_cnt), 32'd1);

        // Ack with fault still present is ignored; clean ack starts holdoff
        step(1'b0, 5'b00100, '0, 1'b0, 1'b0, 1'b1);
        chk("ack_ign_lat", 32'(fault_latched), 32'h04);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("ack_clr_lat", 32'(fault_latched), 32'd0);
        chk("ack_clr_alarm", 32'(alarm_b), 32'd1);
        idle(15, '0);
        chk("hold_a15_rf", 32'(rf_perm_b), 32'd1);
        idle(1, '0);
        chk("hold_a16_rf", 32'(rf_perm_b), 32'd0);

        // First-fault capture with a later second latch
        idle(2, 5'b00001);
        idle(4, 5'b01001);
        chk("ff_lat", 32'(fault_latched), 32'h09);
        chk("ff_first", 32'(first_fault), 32'h01);
        chk("ff_cnt", 32'(trip_cnt), 32'd2);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(H, '0);

        // Interlock inputs in PERMIT
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("g2_rf", 32'(rf_perm_b), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("dr_rf", 32'(rf_perm_b), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("ok_rf", 32'(rf_perm_b), 32'd0);
        chk("ok_cnt", 32'(trip_cnt), 32'd2);

        // Masked channel never latches
        for (int k = 0; k < 10; k++) step(1'b0, 5'b00010, 5'b00010, 1'b0, 1'b0, 1'b0);
        chk("mask_lat", 32'(fault_latched), 32'd0);

        // Simultaneous latch
        idle(4, 5'b10010);
        chk("sim_first", 32'(first_fault), 32'h12);
        chk("sim_cnt", 32'(trip_cnt), 32'd3);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Randomized phase with slowly varying fault patterns
        rf_v = '0; rm_v = '0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) rf_v = N'($urandom) & N'($urandom);
            if ($urandom_range(15) == 0) rm_v = N'($urandom) & N'($urandom);
            rg_v = ($urandom_range(9) == 0);
            rd_v = ($urandom_range(9) == 0);
            ra_v = ($urandom_range(3) == 0);
            step(1'b0, rf_v, rm_v, rg_v, rd_v, ra_v);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Trip counter saturation
        for (int k = 0; k < 260; k++) begin
            idle(D, 5'b00001);
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        chk("sat_cnt", 32'(trip_cnt), 32'd255);
        idle(D, 5'b00001);
        chk("sat_hold", 32'(trip_cnt), 32'd255);

        // Reset while in TRIP
        step(1'b1, 5'b00001, '0, 1'b0, 1'b0, 1'b0);
        chk("rtrip_lat", 32'(fault_latched), 32'd0);
        chk("rtrip_first", 32'(first_fault), 32'd0);
        chk("rtrip_alarm", 32'(alarm_b), 32'd1);
        chk("rtrip_rf", 32'(rf_perm_b), 32'd1);
        chk("rtrip_cnt", 32'(trip_cnt), 32'd0);
        idle(H, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
